button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Upstream conditioning stage for the five Nexys4 push-buttons (BtnC/U/D/L/R) before they reach the game logic (vga_bitchange) and cursor/plant-placement control.
- Per button: synchronises the raw asynchronous input, debounces it with a per-button FSM, and emits a clean level, a one-cycle press pulse and a one-cycle release pulse.
- Game logic consumes press pulses so one physical press moves the cursor or places a plant exactly once.

Parameters:
- NUM_BTN, 5: number of independent button channels; bit order {C,U,D,L,R} = [4:0].
- DEBOUNCE_CYCLES, 1000000: stable-input cycles required to accept a change (10 ms at 100 MHz); legal minimum 2.
- REPEAT_DELAY, 50000000: cycles held before the first auto-repeat pulse (BTN_AUTOREPEAT_EN only).
- REPEAT_PERIOD, 10000000: cycles between later auto-repeat pulses (BTN_AUTOREPEAT_EN only).

Ports:
- clk  in  1  system clock (100 MHz ClkPort).
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  NUM_BTN  raw asynchronous button inputs, active-high.
- btn_level  out  NUM_BTN  debounced button state.
- btn_press  out  NUM_BTN  one-cycle pulse on an accepted press (and on auto-repeat when enabled).
- btn_release  out  NUM_BTN  one-cycle pulse on an accepted release.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - All flops, including both synchroniser stages, clear on reset.
- Outputs after reset:
  - btn_level, btn_press and btn_release are all 0.
  - All FSMs are in IDLE and all counters are 0.
- Synchroniser: two-flop chain per bit; sync = second stage.
- Per-channel FSM (channels fully independent), 2-bit state, counter width $clog2(DEBOUNCE_CYCLES):
  - IDLE (level 0): sync=1 -> PCHK with cnt=0; otherwise stay.
  - PCHK (level 0):
    - sync=0 -> IDLE, cnt=0 (bounce rejected, no pulse).
    - sync=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, btn_press=1 for that one cycle.
    - Otherwise cnt+1.
  - HELD (level 1): sync=0 -> RCHK with cnt=0; otherwise stay.
  - RCHK (level 1):
    - sync=1 -> HELD, cnt=0 (no pulse).
    - sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_release=1 for that one cycle.
    - Otherwise cnt+1.
- Outputs:
  - btn_level is registered: 1 exactly when state is HELD or RCHK.
  - Pulses are registered and never exceed one cycle.
- Latency: with raw input stable from clock edge 1, sync is high after edge 2, the FSM enters PCHK at edge 3, and btn_press plus btn_level rise at edge DEBOUNCE_CYCLES+3. Release is symmetric.
- Boundary conditions:
  - Press and release pulses for the same channel never coincide.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse and no level change.
  - Counters saturate by design at DEBOUNCE_CYCLES-1 and never wrap.
  - Simultaneous presses on several channels are each reported in their own cycle, independently; no arbitration.
  - Reset mid-debounce or while HELD: all outputs drop to 0 on the next edge and no release pulse is generated. A button still held after reset deasserts is re-debounced and yields a fresh btn_press.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat counter, cleared on entry to HELD.
  - After REPEAT_DELAY cycles continuously in HELD, btn_press pulses once, then again every REPEAT_PERIOD cycles while still in HELD.
  - The counter freezes in RCHK and resumes if the FSM returns to HELD; it clears on IDLE and on reset.
- Not defined:
  - No repeat counter logic is built.
  - Exactly one btn_press per accepted press, regardless of hold time.

Test Plan (DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=16):
- Reset asserted 3 cycles with btn_raw=5'b11111 -> all outputs 0 during reset; after deassert, btn_press=5'b11111 for one cycle at edge 11 after release of reset, btn_level=5'b11111 thereafter.
- btn_raw[3] (BtnU) high, stable for 20 cycles -> btn_press[3] single pulse exactly 11 edges after first sample; btn_level[3]=1; other bits stay 0.
- btn_raw[1] toggles 1,0,1,0 each 3 cycles, then stays 0 -> no pulses, btn_level[1] stays 0.
- BtnU held, then released with a 4-cycle bounce before stable low -> single btn_release[3] 11 edges after the final stable low sample; no extra press pulse.
- BtnL and BtnR rise on the same edge -> btn_press[1] and btn_press[0] pulse in the same cycle; reset asserted mid-HELD -> level drops next edge, no release pulse.
- BTN_AUTOREPEAT_EN defined, BtnD held 100 cycles after acceptance -> press pulses at acceptance, +40, +56, +72, +88; without the macro -> single pulse only.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, per-channel debounce FSM, level/press/release outputs.
// Optional auto-repeat of btn_press while held is built when BTN_AUTOREPEAT_EN is defined.
`timescale 1ns/1ps
module button_conditioner #(
    parameter int unsigned NUM_BTN         = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_cfg_check
        $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PCHK = 2'd1,
        HELD = 2'd2,
        RCHK = 2'd3
    } state_t;

    logic [NUM_BTN-1:0] meta_q;
    logic [NUM_BTN-1:0] sync_q;
    state_t             state_q [NUM_BTN];
    state_t             state_d [NUM_BTN];
    logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] press_d;
    logic [NUM_BTN-1:0] release_d;
`ifdef BTN_AUTOREPEAT_EN
    logic [RPT_W-1:0]   rpt_q   [NUM_BTN];
    logic [RPT_W-1:0]   rpt_d   [NUM_BTN];
    logic [NUM_BTN-1:0] rep_q;
    logic [NUM_BTN-1:0] rep_d;
`endif

    // Next-state and pulse generation, one independent FSM per channel.
    always_comb begin
        level_d   = '0;
        press_d   = '0;
        release_d = '0;
`ifdef BTN_AUTOREPEAT_EN
        rep_d     = rep_q;
`endif
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
`ifdef BTN_AUTOREPEAT_EN
            rpt_d[i]   = rpt_q[i];
`endif
            unique case (state_q[i])
                IDLE: begin
`ifdef BTN_AUTOREPEAT_EN
                    rpt_d[i] = '0;
                    rep_d[i] = 1'b0;
`endif
                    if (sync_q[i]) begin
                        state_d[i] = PCHK;
                        cnt_d[i]   = '0;
                    end
                end
                PCHK: begin
                    if (!sync_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        state_d[i] = HELD;
                        press_d[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rpt_d[i]   = '0;
                        rep_d[i]   = 1'b0;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!sync_q[i]) begin
                        state_d[i] = RCHK;
                        cnt_d[i]   = '0;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    // First repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD.
                    else if (!rep_q[i]) begin
                        if (rpt_q[i] == RPT_W'(REPEAT_DELAY - 1)) begin
                            press_d[i] = 1'b1;
                            rpt_d[i]   = '0;
                            rep_d[i]   = 1'b1;
                        end else begin
                            rpt_d[i] = rpt_q[i] + RPT_W'(1);
                        end
                    end else if (rpt_q[i] == RPT_W'(REPEAT_PERIOD - 1)) begin
                        press_d[i] = 1'b1;
                        rpt_d[i]   = '0;
                    end else begin
                        rpt_d[i] = rpt_q[i] + RPT_W'(1);
                    end
`endif
                end
                RCHK: begin
                    if (sync_q[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        state_d[i]   = IDLE;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            level_d[i] = (state_d[i] == HELD) || (state_d[i] == RCHK);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q      <= '0;
            sync_q      <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                rpt_q[i]   <= '0;
`endif
            end
`ifdef BTN_AUTOREPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            meta_q      <= btn_raw;
            sync_q      <= meta_q;
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef BTN_AUTOREPEAT_EN
                rpt_q[i]   <= rpt_d[i];
`endif
            end
`ifdef BTN_AUTOREPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

endmodule
